// File: rtl/wb_mem_slave.sv
// ----------------------------------------------------------------------------
// wb_mem_slave
//   Wishbone classic single-transfer slave: on-chip word RAM with byte-lane
//   write enables, a fixed number of programmable wait states before the
//   response, and error termination for addresses outside the RAM window.
//
//   Optional feature macro: WB_MEM_SLAVE_LED_EN
//     When defined, the word just past the RAM (index DEPTH) is a read/write
//     LED register that drives led_o. When undefined, led_o does not exist
//     and index DEPTH decodes as a miss.
//
// Ports
//   wb_clk_i      sole clock, rising edge
//   wb_reset_n_i  reset, asynchronous assert, active-low
//   wb_addr_i     byte address
//   wb_data_i     write data
//   wb_sel_i      byte lane enables
//   wb_we_i       1 = write, 0 = read
//   wb_cyc_i      cycle valid
//   wb_stb_i      strobe
//   wb_data_o     read data, non-zero only during the ack cycle
//   wb_ack_o      normal termination, one-cycle pulse
//   wb_err_o      error termination, one-cycle pulse
//   wb_stall_o    always 0 (classic cycles)
//   wb_rty_o      always 0
//   led_o         LED register (WB_MEM_SLAVE_LED_EN only)
// ----------------------------------------------------------------------------
module wb_mem_slave #(
   parameter int                       WB_BUS_WIDTH  = 16,
   parameter int                       WB_ADDR_WIDTH = 32,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                       DEPTH         = 256,
   parameter int                       WAIT_STATES   = 0,
   parameter int                       LED_WIDTH     = 16
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_reset_n_i,
   input  logic [WB_ADDR_WIDTH-1:0]   wb_addr_i,
   input  logic [WB_BUS_WIDTH-1:0]    wb_data_i,
   input  logic [WB_BUS_WIDTH/8-1:0]  wb_sel_i,
   input  logic                       wb_we_i,
   input  logic                       wb_cyc_i,
   input  logic                       wb_stb_i,
   output logic [WB_BUS_WIDTH-1:0]    wb_data_o,
   output logic                       wb_ack_o,
   output logic                       wb_err_o,
   output logic                       wb_stall_o,
   output logic                       wb_rty_o
`ifdef WB_MEM_SLAVE_LED_EN
   ,
   output logic [LED_WIDTH-1:0]       led_o
`endif
);

   localparam int SEL = WB_BUS_WIDTH / 8;
   localparam int OFF = (SEL > 1) ? $clog2(SEL) : 0;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // ---------------------------------------------------------------- decode
   logic [WB_ADDR_WIDTH-1:0] rel_addr;
   logic [WB_ADDR_WIDTH-1:0] word_addr;
   logic                     in_hit;
   logic                     in_led;
   logic [AW-1:0]            in_idx;
   logic                     req;

   // Subtracting the base makes addresses below the window wrap to large
   // values, so a single upper-bound compare covers both sides.
   assign rel_addr  = wb_addr_i - BASE_ADDR;
   assign word_addr = rel_addr >> OFF;
   assign in_hit    = word_addr < WB_ADDR_WIDTH'(DEPTH);
   assign in_idx    = word_addr[AW-1:0];
   assign req       = wb_cyc_i & wb_stb_i;

`ifdef WB_MEM_SLAVE_LED_EN
   assign in_led = (word_addr == WB_ADDR_WIDTH'(DEPTH));
`else
   assign in_led = 1'b0;
`endif

   // ---------------------------------------------------------------- state
   logic [1:0]              state_reg;
   logic [3:0]              cnt_reg;
   logic [AW-1:0]           addr_reg;
   logic [WB_BUS_WIDTH-1:0] data_reg;
   logic [SEL-1:0]          sel_reg;
   logic                    we_reg;
   logic                    hit_reg;
   logic                    led_sel_reg;
   logic                    ack_reg;
   logic                    err_reg;

   // Transaction fields seen at the commit edge. With zero wait states the
   // commit happens on the sampling edge itself, so the live inputs are used;
   // otherwise the latched copy is.
   logic                    go;
   logic [AW-1:0]           c_idx;
   logic [WB_BUS_WIDTH-1:0] c_data;
   logic [SEL-1:0]          c_sel;
   logic                    c_we;
   logic                    c_hit;
   logic                    c_led;
   logic                    ram_we;
   logic                    led_we;

   always_comb begin
      go     = 1'b0;
      c_idx  = addr_reg;
      c_data = data_reg;
      c_sel  = sel_reg;
      c_we   = we_reg;
      c_hit  = hit_reg;
      c_led  = led_sel_reg;
      case (state_reg)
         S_IDLE: begin
            c_idx  = in_idx;
            c_data = wb_data_i;
            c_sel  = wb_sel_i;
            c_we   = wb_we_i;
            c_hit  = in_hit | in_led;
            c_led  = in_led;
            go     = req && (WAIT_STATES == 0);
         end
         S_WAIT:  go = wb_cyc_i && (cnt_reg == 4'd0);
         default: go = 1'b0;
      endcase
   end

   // The RAM block has no reset term, so gate writes while reset is held.
   assign ram_we = go & wb_reset_n_i & c_we & c_hit & ~c_led;
   assign led_we = go & wb_reset_n_i & c_we & c_led;

   always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
      if (!wb_reset_n_i) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= 4'd0;
         addr_reg    <= '0;
         data_reg    <= '0;
         sel_reg     <= '0;
         we_reg      <= 1'b0;
         hit_reg     <= 1'b0;
         led_sel_reg <= 1'b0;
         ack_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         if (go) begin
            ack_reg <= c_hit;
            err_reg <= ~c_hit;
         end
         case (state_reg)
            S_IDLE: begin
               if (req) begin
                  addr_reg    <= in_idx;
                  data_reg    <= wb_data_i;
                  sel_reg     <= wb_sel_i;
                  we_reg      <= wb_we_i;
                  hit_reg     <= in_hit | in_led;
                  led_sel_reg <= in_led;
                  cnt_reg     <= WS_LOAD;
                  state_reg   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               // Master abandoning the cycle cancels it with no side effects.
               if (!wb_cyc_i) begin
                  state_reg <= S_IDLE;
               end else if (cnt_reg == 4'd0) begin
                  state_reg <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RAM
   logic [WB_BUS_WIDTH-1:0] ram [DEPTH];
   logic [WB_BUS_WIDTH-1:0] ram_q;

   // Write and read share the commit edge; the read port sees the pre-write
   // contents, but reads and writes are never the same transaction.
   always_ff @(posedge wb_clk_i) begin
      if (ram_we) begin
         for (int b = 0; b < SEL; b++) begin
            if (c_sel[b]) begin
               ram[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
            end
         end
      end
      if (go) begin
         ram_q <= ram[c_idx];
      end
   end

   // ---------------------------------------------------------------- LED
   logic [WB_BUS_WIDTH-1:0] led_word;

`ifdef WB_MEM_SLAVE_LED_EN
   logic [LED_WIDTH-1:0] led_reg;

   always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
      if (!wb_reset_n_i) begin
         led_reg <= '0;
      end else if (led_we) begin
         for (int b = 0; b < LED_WIDTH; b++) begin
            if (c_sel[b/8]) begin
               led_reg[b] <= c_data[b];
            end
         end
      end
   end

   assign led_o    = led_reg;
   assign led_word = WB_BUS_WIDTH'(led_reg);
`else
   assign led_word = '0;
`endif

   // ---------------------------------------------------------------- outputs
   assign wb_data_o  = ack_reg ? (led_sel_reg ? led_word : ram_q) : '0;
   assign wb_ack_o   = ack_reg;
   assign wb_err_o   = err_reg;
   assign wb_stall_o = 1'b0;
   assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_wb_mem_slave
//   Directed bench for wb_mem_slave. Instance a uses two wait states, instance
//   b uses three (for the abort case); a select bit steers cyc to one of them.
//   Build with WB_MEM_SLAVE_LED_EN defined to include the LED register steps.
// ----------------------------------------------------------------------------
module tb_wb_mem_slave;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  sel = '0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        use_b = 1'b0;

   logic        cyc_a, cyc_b;
   logic [15:0] data_a, data_b;
   logic        ack_a, ack_b, err_a, err_b;
   logic        stall_a, stall_b, rty_a, rty_b;
`ifdef WB_MEM_SLAVE_LED_EN
   logic [15:0] led_a, led_b;
`endif

   assign cyc_a = cyc & ~use_b;
   assign cyc_b = cyc & use_b;

   always #5 clk = ~clk;

   wb_mem_slave #(.WB_BUS_WIDTH(16), .WB_ADDR_WIDTH(32), .BASE_ADDR(BASE),
                  .DEPTH(DEPTH), .WAIT_STATES(2), .LED_WIDTH(16)) u_dut_a (
      .wb_clk_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdata),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb),
      .wb_data_o(data_a), .wb_ack_o(ack_a), .wb_err_o(err_a),
      .wb_stall_o(stall_a), .wb_rty_o(rty_a)
`ifdef WB_MEM_SLAVE_LED_EN
      , .led_o(led_a)
`endif
   );

   wb_mem_slave #(.WB_BUS_WIDTH(16), .WB_ADDR_WIDTH(32), .BASE_ADDR(BASE),
                  .DEPTH(DEPTH), .WAIT_STATES(3), .LED_WIDTH(16)) u_dut_b (
      .wb_clk_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdata),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb),
      .wb_data_o(data_b), .wb_ack_o(ack_b), .wb_err_o(err_b),
      .wb_stall_o(stall_b), .wb_rty_o(rty_b)
`ifdef WB_MEM_SLAVE_LED_EN
      , .led_o(led_b)
`endif
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One classic transfer on the selected instance. ack_k/err_k give the
   // number of rising edges after the sampling edge before the response is
   // visible (WAIT_STATES), -1 if it never appears; width counts how many
   // consecutive sample points showed a response (1 expected).
   task automatic xfer(input logic [31:0] a, input logic [15:0] d, input logic [1:0] s,
                       input logic w, output logic [15:0] rd, output int ack_k,
                       output int err_k, output int width);
      logic seen;
      ack_k = -1; err_k = -1; width = 0; rd = '0; seen = 1'b0;
      @(negedge clk);
      addr = a; wdata = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if ((use_b ? ack_b : ack_a) || (use_b ? err_b : err_a)) begin
            seen  = 1'b1;
            ack_k = (use_b ? ack_b : ack_a) ? k : -1;
            err_k = (use_b ? err_b : err_a) ? k : -1;
            rd    = use_b ? data_b : data_a;
            width = 1;
            cyc = 1'b0; stb = 1'b0;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      if ((use_b ? ack_b : ack_a) || (use_b ? err_b : err_a)) width++;
   endtask

   logic [15:0] rd;
   int          ak, ek, wd, spurious;

   initial begin
      // ---- reset held with a request asserted: no response at all
      rst_n = 1'b0;
      @(negedge clk);
      addr = BASE + 32'd4; wdata = 16'h1111; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_ack",   32'(ack_a), 32'd0);
      chk("rst_err",   32'(err_a), 32'd0);
      chk("rst_data",  32'(data_a), 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      chk("rst_rty",   32'(rty_a), 32'd0);
`ifdef WB_MEM_SLAVE_LED_EN
      chk("rst_led",   32'(led_a), 32'd0);
`endif
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- write / read with two wait states
      xfer(BASE + 32'd4, 16'hA5C3, 2'b11, 1'b1, rd, ak, ek, wd);
      chk("wr_ack_lat", 32'(ak), 32'd2);
      chk("wr_no_err",  32'(ek), 32'hFFFF_FFFF);
      chk("wr_width",   32'(wd), 32'd1);
      chk("idle_data",  32'(data_a), 32'd0);
      xfer(BASE + 32'd4, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("rd_ack_lat", 32'(ak), 32'd2);
      chk("rd_width",   32'(wd), 32'd1);
      chk("rd_data",    32'(rd), 32'h0000_A5C3);

      // ---- byte lanes, ignored byte offset, sel=0 write
      xfer(BASE + 32'd8, 16'h1234, 2'b11, 1'b1, rd, ak, ek, wd);
      xfer(BASE + 32'd8, 16'hFF00, 2'b10, 1'b1, rd, ak, ek, wd);
      xfer(BASE + 32'd8, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("lane_data",  32'(rd), 32'h0000_FF34);
      xfer(BASE + 32'd8, 16'hFFFF, 2'b00, 1'b1, rd, ak, ek, wd);
      chk("sel0_ack",   32'(ak), 32'd2);
      xfer(BASE + 32'd9, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("sel0_data",  32'(rd), 32'h0000_FF34);
      xfer(BASE + 32'd2 * DEPTH - 32'd2, 16'hBEEF, 2'b11, 1'b1, rd, ak, ek, wd);
      chk("last_word_ack", 32'(ak), 32'd2);

      // ---- misses
      xfer(BASE + 32'd2 * DEPTH + 32'd2, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("miss_err_lat", 32'(ek), 32'd2);
      chk("miss_no_ack",  32'(ak), 32'hFFFF_FFFF);
      chk("miss_data",    32'(rd), 32'd0);
      chk("miss_width",   32'(wd), 32'd1);
      xfer(BASE - 32'd2, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("below_base_err", 32'(ek), 32'd2);
`ifndef WB_MEM_SLAVE_LED_EN
      xfer(BASE + 32'd2 * DEPTH, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("idx_depth_err", 32'(ek), 32'd2);
`endif
      xfer(BASE + 32'd2 * DEPTH + 32'd2, 16'hDEAD, 2'b11, 1'b1, rd, ak, ek, wd);
      chk("miss_wr_err", 32'(ek), 32'd2);
      xfer(BASE + 32'd4, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("miss_wr_keep4", 32'(rd), 32'h0000_A5C3);
      xfer(BASE + 32'd8, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("miss_wr_keep8", 32'(rd), 32'h0000_FF34);
      xfer(BASE + 32'd2 * DEPTH - 32'd2, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("miss_wr_keep_last", 32'(rd), 32'h0000_BEEF);

      // ---- abort on the three-wait-state instance
      use_b = 1'b1;
      xfer(BASE + 32'h10, 16'h7777, 2'b11, 1'b1, rd, ak, ek, wd);
      chk("b_wr_ack_lat", 32'(ak), 32'd3);
      @(negedge clk);
      addr = BASE + 32'h10; wdata = 16'h0BAD; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      spurious = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ack_b || err_b) spurious++;
      end
      chk("abort_no_resp", 32'(spurious), 32'd0);
      xfer(BASE + 32'h10, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("abort_keep", 32'(rd), 32'h0000_7777);
      use_b = 1'b0;

`ifdef WB_MEM_SLAVE_LED_EN
      // ---- LED register at index DEPTH
      xfer(BASE + 32'd2 * DEPTH, 16'h00F0, 2'b11, 1'b1, rd, ak, ek, wd);
      chk("led_wr_ack", 32'(ak), 32'd2);
      chk("led_value",  32'(led_a), 32'h0000_00F0);
      xfer(BASE + 32'd2 * DEPTH, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("led_readback", 32'(rd), 32'h0000_00F0);
      xfer(BASE + 32'd2 * DEPTH, 16'hAB11, 2'b10, 1'b1, rd, ak, ek, wd);
      chk("led_lane", 32'(led_a), 32'h0000_ABF0);
`endif

      // ---- reset in the middle of a wait: write dropped, no response
      @(negedge clk);
      addr = BASE + 32'd4; wdata = 16'h5555; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack_a), 32'd0);
      chk("midrst_err", 32'(err_a), 32'd0);
`ifdef WB_MEM_SLAVE_LED_EN
      chk("midrst_led", 32'(led_a), 32'd0);
`endif
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(BASE + 32'd4, 16'h0000, 2'b11, 1'b0, rd, ak, ek, wd);
      chk("midrst_ack_after", 32'(ak), 32'd2);
      chk("midrst_keep", 32'(rd), 32'h0000_A5C3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
